// File: rtl/acc_alu_unit.sv
// Accumulator/ALU stage fed by the operand mux. Single-cycle ops commit on the next edge.
// MUL is an iterative shift-add taking WIDTH extra cycles, with a busy/done handshake.
module acc_alu_unit #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand,
    input  logic [2:0]       opcode,
    input  logic             start,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] multiplicand;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_next;
    logic [WIDTH-1:0]   multiplier;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_acc;
    logic               alu_carry;

    // The top bit of the widened difference is the unsigned borrow.
    always_comb begin
        sum          = {1'b0, acc} + {1'b0, operand};
        diff         = {1'b0, acc} - {1'b0, operand};
        product_next = product + (multiplier[0] ? multiplicand : '0);
        alu_acc      = acc;
        alu_carry    = carry;
        case (opcode)
            OP_LOAD: begin
                alu_acc   = operand;
                alu_carry = 1'b0;
            end
            OP_ADD:  {alu_carry, alu_acc} = sum;
            OP_SUB:  {alu_carry, alu_acc} = diff;
            OP_AND:  alu_acc = acc & operand;
            OP_OR:   alu_acc = acc | operand;
            OP_XOR:  alu_acc = acc ^ operand;
            OP_SHL: begin
                alu_carry = acc[WIDTH-1];
                alu_acc   = {acc[WIDTH-2:0], 1'b0};
            end
            default: begin
                alu_acc   = acc;
                alu_carry = carry;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            carry        <= 1'b0;
            zero         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            multiplicand <= '0;
            multiplier   <= '0;
            product      <= '0;
            count        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (opcode == OP_MUL && MUL_EN) begin
                            multiplicand <= {{WIDTH{1'b0}}, acc};
                            multiplier   <= operand;
                            product      <= '0;
                            count        <= '0;
                            busy         <= 1'b1;
                            state        <= MUL;
                        end else begin
                            acc   <= alu_acc;
                            carry <= alu_carry;
                            zero  <= (alu_acc == '0);
                            done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // The last step commits product_next so the final add is not lost.
                    product      <= product_next;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + CW'(1);
                    if (count == LAST) begin
                        acc   <= product_next[WIDTH-1:0];
                        carry <= |product_next[2*WIDTH-1:WIDTH];
                        zero  <= (product_next[WIDTH-1:0] == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu_unit.sv
// Self-checking bench for acc_alu_unit: directed scenarios plus random ops checked
// against an arithmetic reference model; a second instance covers MUL_EN=0.
module tb_acc_alu_unit;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] operand = '0;
    logic [2:0] opcode = '0;
    logic       start = 1'b0;
    logic [7:0] acc;
    logic       carry, zero, busy, done;

    logic [7:0] operand_n = '0;
    logic [2:0] opcode_n = '0;
    logic       start_n = 1'b0;
    logic [7:0] acc_n;
    logic       carry_n, zero_n, busy_n, done_n;

    logic [11:0] obs, obs_n, want;
    int          tests = 0;
    int          failures = 0;
    logic [7:0]  m_acc = '0;
    logic        m_carry = 1'b0;

    assign obs   = {acc, carry, zero, busy, done};
    assign obs_n = {acc_n, carry_n, zero_n, busy_n, done_n};

    acc_alu_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .operand(operand), .opcode(opcode), .start(start),
        .acc(acc), .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    acc_alu_unit #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset), .operand(operand_n), .opcode(opcode_n), .start(start_n),
        .acc(acc_n), .carry(carry_n), .zero(zero_n), .busy(busy_n), .done(done_n)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the accumulator value.
    function automatic void ref_op(input logic [2:0] op, input logic [7:0] v);
        int a, b, r;
        a = int'(m_acc);
        b = int'(v);
        r = a;
        case (op)
            OP_LOAD: begin r = b; m_carry = 1'b0; end
            OP_ADD:  begin r = a + b; m_carry = (r > 255); end
            OP_SUB:  begin m_carry = (a < b); r = a - b + 256; end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  begin m_carry = (a >= 128); r = a * 2; end
            default: begin r = a * b; m_carry = (r > 255); end
        endcase
        m_acc = 8'(r % 256);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [7:0] val);
        opcode  = op;
        operand = val;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Waits for done after a MUL was issued; optionally pulses start while busy.
    task automatic wait_done(output int edges, output bit busy_ok, input bit noise);
        edges   = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noise) begin
                start   = 1'($urandom);
                opcode  = 3'($urandom);
                operand = 8'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        want = {8'h00, 4'b0100};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL reset_init: got %h expected %h", obs, want); end
        tests++;
        if (obs_n !== want) begin failures++; $display("[TB] FAIL reset_init_nomul: got %h expected %h", obs_n, want); end
        reset = 1'b0;
        issue(OP_LOAD, 8'h07);
        issue(OP_MUL, 8'h03);
        want = {8'h07, 4'b0010};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL mul_inflight: got %h expected %h", obs, want); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            want = {8'h00, 4'b0100};
            tests++;
            if (obs !== want) begin failures++; $display("[TB] FAIL reset_mid_mul%0d: got %h expected %h", i, obs, want); end
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        want = {8'h00, 4'b0100};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL reset_no_stray_done: got %h expected %h", obs, want); end
        issue(OP_LOAD, 8'h11);
        want = {8'h11, 4'b0001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL resume_load: got %h expected %h", obs, want); end
    endtask

    task automatic test_load_add;
        issue(OP_LOAD, 8'hF0);
        want = {8'hF0, 4'b0001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL load_f0: got %h expected %h", obs, want); end
        issue(OP_ADD, 8'h20);
        want = {8'h10, 4'b1001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL add_carry: got %h expected %h", obs, want); end
        @(negedge clk);
        want = {8'h10, 4'b1000};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL done_single_pulse: got %h expected %h", obs, want); end
    endtask

    task automatic test_sub;
        issue(OP_LOAD, 8'h05);
        want = {8'h05, 4'b0001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL load_05: got %h expected %h", obs, want); end
        issue(OP_SUB, 8'h05);
        want = {8'h00, 4'b0101};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL sub_to_zero: got %h expected %h", obs, want); end
        issue(OP_SUB, 8'h01);
        want = {8'hFF, 4'b1001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL sub_borrow: got %h expected %h", obs, want); end
    endtask

    task automatic test_shl_xor;
        issue(OP_LOAD, 8'h81);
        issue(OP_SHL, 8'($urandom));
        want = {8'h02, 4'b1001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL shl_out: got %h expected %h", obs, want); end
        issue(OP_XOR, 8'h02);
        want = {8'h00, 4'b1101};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL xor_keeps_carry: got %h expected %h", obs, want); end
    endtask

    task automatic test_mul;
        int edges;
        bit busy_ok;
        issue(OP_LOAD, 8'h0C);
        issue(OP_MUL, 8'h0B);
        wait_done(edges, busy_ok, 1'b1);
        tests++;
        if (edges !== 9) begin failures++; $display("[TB] FAIL mul_latency: got %0d expected 9", edges); end
        tests++;
        if (busy_ok !== 1'b1) begin failures++; $display("[TB] FAIL mul_busy_held: got %0d expected 1", busy_ok); end
        want = {8'h84, 4'b0001};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL mul_result: got %h expected %h", obs, want); end
        @(negedge clk);
        want = {8'h84, 4'b0000};
        tests++;
        if (obs !== want) begin failures++; $display("[TB] FAIL mul_done_pulse: got %h expected %h", obs, want); end
    endtask

    task automatic test_mul_overflow;
        int edges;
        bit busy_ok;
        issue(OP_LOAD, 8'h20);
        issue(OP_MUL, 8'h10);
        wait_done(edges, busy_ok, 1'b0);
        want = {8'h00, 4'b1101};
        tests++;
        if (obs !== want || edges !== 9) begin
            failures++;
            $display("[TB] FAIL mul_overflow: got %h after %0d edges expected %h after 9", obs, edges, want);
        end
    endtask

    task automatic test_mul_disabled;
        opcode_n = OP_LOAD; operand_n = 8'h20; start_n = 1'b1;
        @(negedge clk);
        opcode_n = OP_MUL; operand_n = 8'h10;
        @(negedge clk);
        start_n = 1'b0;
        want = {8'h20, 4'b0001};
        tests++;
        if (obs_n !== want) begin failures++; $display("[TB] FAIL nomul_mul_nop: got %h expected %h", obs_n, want); end
        @(negedge clk);
        want = {8'h20, 4'b0000};
        tests++;
        if (obs_n !== want) begin failures++; $display("[TB] FAIL nomul_idle: got %h expected %h", obs_n, want); end
        opcode_n = OP_LOAD; operand_n = 8'hFF; start_n = 1'b1;
        @(negedge clk);
        opcode_n = OP_ADD; operand_n = 8'h01;
        @(negedge clk);
        opcode_n = OP_MUL; operand_n = 8'h33;
        @(negedge clk);
        start_n = 1'b0;
        want = {8'h00, 4'b1101};
        tests++;
        if (obs_n !== want) begin failures++; $display("[TB] FAIL nomul_keeps_carry: got %h expected %h", obs_n, want); end
    endtask

    task automatic test_random;
        logic [2:0] op;
        logic [7:0] v;
        int edges;
        bit busy_ok;
        v = 8'($urandom);
        issue(OP_LOAD, v);
        ref_op(OP_LOAD, v);
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            v  = 8'($urandom);
            ref_op(op, v);
            issue(op, v);
            edges = 1;
            if (op == OP_MUL) wait_done(edges, busy_ok, 1'b1);
            want = {m_acc, m_carry, (m_acc == 8'h00), 1'b0, 1'b1};
            tests++;
            if (obs !== want || (op == OP_MUL && edges !== 9)) begin
                failures++;
                $display("[TB] FAIL random_op%0d (op %0d val %h): got %h after %0d edges expected %h",
                         i, op, v, obs, edges, want);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                want = {m_acc, m_carry, (m_acc == 8'h00), 1'b0, 1'b0};
                tests++;
                if (obs !== want) begin failures++; $display("[TB] FAIL random_idle%0d: got %h expected %h", i, obs, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_sub();
        test_shl_xor();
        test_mul();
        test_mul_overflow();
        test_mul_disabled();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/acc_alu_unit.md
Name: acc_alu_unit

Overview:
- Accumulator/ALU stage directly downstream of the 8-bit 4:1 operand mux; consumes the selected operand and updates the processor accumulator.
- Single-cycle ops complete on the next edge. MUL is iterative shift-add over WIDTH cycles, with a busy/done handshake to the controller.
- Accumulator value is fed back to the controller and to a mux input.

Parameters:
- WIDTH, 8, datapath width of operand and accumulator.
- MUL_EN, 1, 1 = MUL opcode supported; 0 = MUL treated as NOP (done still pulses).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- operand  in  WIDTH  selected operand from the 4:1 mux
- opcode  in  3  000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SHL, 111 MUL
- start  in  1  one-cycle request; sampled only when busy=0
- acc  out  WIDTH  accumulator register
- carry  out  1  carry/borrow/shift-out flag
- zero  out  1  1 when acc == 0 (registered with acc)
- busy  out  1  1 while a MUL is in progress
- done  out  1  one-cycle pulse when an op commits to acc

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high.
- Reset values, at the first clk edge with reset=1: acc=0, carry=0, zero=1, busy=0, done=0, FSM=IDLE, multiplier counters cleared.
- Reset has priority over all other inputs, including mid-MUL: the MUL is aborted, no done pulse, and acc=0.
- FSM states are IDLE and MUL.
- IDLE, start=1, opcode != MUL (or MUL_EN=0): next edge commits the result to acc, updates carry/zero, and sets done=1 for exactly one cycle. FSM stays IDLE, so a back-to-back start on consecutive cycles is accepted every cycle.
- Single-cycle op semantics:
  - LOAD: acc=operand, carry=0.
  - ADD: {carry,acc}=acc+operand (WIDTH+1-bit sum).
  - SUB: acc=acc-operand mod 2^WIDTH; carry=1 when borrow (acc<operand, unsigned).
  - AND/OR/XOR: bitwise; carry unchanged.
  - SHL: carry=acc[WIDTH-1], acc={acc[WIDTH-2:0],0}; operand ignored.
  - MUL_EN=0 and MUL: acc, carry unchanged; done pulses.
- IDLE, start=1, opcode=MUL, MUL_EN=1:
  - Next edge: latch multiplicand=acc, multiplier=operand, product=0, count=0. Set busy=1, go to MUL.
  - MUL, each cycle: if multiplier[0], product+=multiplicand (2*WIDTH-bit). Then multiplicand<<=1, multiplier>>=1, count++.
  - After exactly WIDTH MUL cycles: acc=product[WIDTH-1:0]; carry=1 if product[2*WIDTH-1:WIDTH]!=0 (overflow), else 0. busy=0 and done=1 on the same edge; return to IDLE.
  - Total latency from the start edge to done: WIDTH+1 edges (9 for WIDTH=8).
- start while busy=1 is ignored (not queued). operand and opcode are don't-care during MUL; the latched values are used.
- zero is always recomputed from the new acc value on every commit, including AND/OR/XOR.
- done=0 in every cycle without a commit. busy never overlaps a single-cycle commit.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: hold reset 2 cycles, with a MUL in flight (start MUL 3 cycles earlier) -> acc=0x00, zero=1, carry=0, busy=0, no done pulse; resumes cleanly afterward.
- LOAD 0xF0 then ADD 0x20 on consecutive cycles -> acc=0xF0 with done, then acc=0x10, carry=1, zero=0, one done per op.
- LOAD 0x05, SUB 0x05 -> acc=0x00, zero=1, carry=0. Then SUB 0x01 -> acc=0xFF, carry=1 (borrow), zero=0.
- LOAD 0x81, SHL -> acc=0x02, carry=1. Then XOR 0x02 -> acc=0x00, zero=1, carry still 1.
- LOAD 0x0C, MUL 0x0B -> busy=1 for 8 cycles, done on the 9th edge with acc=0x84, carry=0. Start pulses during busy are ignored (acc unaffected).
- LOAD 0x20, MUL 0x10 -> product 0x0200, acc=0x00, carry=1, zero=1. With MUL_EN=0, the same op -> acc stays 0x20, done after 1 cycle, busy never asserted.
